// File: rtl/panxi_spsram_ctrl.sv
// panxi_spsram_ctrl: single-port SRAM with valid/ready request port, byte strobes, optional output register and post-reset zero fill
module panxi_spsram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic                    RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    INIT_DONE
);
  localparam int nb = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] last_addr = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt, wa;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] wd, rd_d;
  logic [nb-1:0] ws;
  logic hs, we, rd_v;
  assign REQ_READY = INIT_DONE;
  assign hs = REQ_VALID && INIT_DONE;
  // array write port: fill sequencer owns it during INIT, requests own it afterwards
  always_comb begin
    we = ARESETn && ((state == INIT) || (hs && REQ_WRITE));
    wa = (state == INIT) ? cnt : REQ_ADDR;
    wd = (state == INIT) ? '0 : REQ_WDATA;
    ws = (state == INIT) ? '1 : REQ_WSTRB;
  end
  // fill sequencer: one zero word per cycle, leaves INIT after the last address
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= (INIT_ZERO != 0) ? INIT : RUN;
      cnt <= '0;
      INIT_DONE <= 1'b0;
    end else begin
      state <= (state == INIT && cnt == last_addr) ? RUN : state;
      cnt <= (state == INIT && cnt != last_addr) ? cnt + ADDR_WIDTH'(1) : cnt;
      INIT_DONE <= (state == RUN) || (cnt == last_addr);
    end
  // storage array with byte-granular writes; contents are never reset
  always_ff @(posedge ACLK)
    for (int i = 0; i < nb; i++)
      if (we && ws[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
  // first read stage: data holds its last value between reads
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      rd_v <= 1'b0;
      rd_d <= '0;
    end else begin
      rd_v <= hs && !REQ_WRITE;
      rd_d <= (hs && !REQ_WRITE) ? mem[REQ_ADDR] : rd_d;
    end
  if (OUT_REG != 0) begin : g_oreg
    logic v2;
    logic [DATA_WIDTH-1:0] d2;
    // optional output register adds one cycle of read latency
    always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= rd_v;
        d2 <= rd_v ? rd_d : d2;
      end
    assign RSP_VALID = v2;
    assign RSP_RDATA = d2;
  end else begin : g_noreg
    assign RSP_VALID = rd_v;
    assign RSP_RDATA = rd_d;
  end
endmodule
